goertzel_frame_sched: RTL and testbench
=======================================

// Module: goertzel_frame_sched
// PURPOSE
//  Ping-pong frame scheduler between the ADC sample stream and the Goertzel magnitude engine.
//  Writes the ADC samples into one bank of a 2-bank DP-RAM frame buffer. Once a bank is full,
//  it streams that bank to the engine, one sample per clock. It frees the bank on engine done.
//  Sits between the ADC capture logic, the DP-RAM (addr = {bank, index}) and dsp_goertzel_manager.
// PARAMETERS
//  B_W          8    sample width (bits)
//  NUM_SAMPLES  512  samples per frame / per bank
//  NS_BITS      9    index width, clog2(NUM_SAMPLES)
// PORTS
//  sys_clk         in   1        system clock, 24 MHz
//  sys_rst         in   1        reset, synchronous, active-high
//  adc_rdy         in   1        ADC enabled; low = writer idle, partial frame discarded
//  adc_data_ready  in   1        sample strobe, async to sys_clk, >=1 clk wide
//  adc_data_in     in   B_W      sample, stable while strobe high
//  wr_en           out  1        DP-RAM write enable (1-cycle pulse)
//  wr_bank         out  1        bank being filled
//  wr_addr         out  NS_BITS  write index
//  wr_data         out  B_W      captured sample
//  rd_en           out  1        DP-RAM read enable
//  rd_bank         out  1        bank being streamed
//  rd_addr         out  NS_BITS  read index
//  eng_start       out  1        1-cycle pulse, frame start to engine (engine clears accumulators)
//  sample_valid    out  1        RAM read data valid to engine (rd_en delayed 1 clk)
//  sample_last     out  1        with sample_valid on final sample of frame
//  eng_done        in   1        engine magnitude ready (mag_rdy pulse)
//  frame_done      out  1        1-cycle pulse, bank released
//  overrun         out  1        1-cycle pulse, completed frame dropped
//  overrun_cnt     out  8        dropped-frame count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: every output 0; wr_bank=0; full[1:0]=00; writer/reader FSMs idle; index counters 0.
//  Strobe input: 2-flop synchroniser + rising-edge detect.
//   - Exactly one write per strobe, regardless of strobe width.
//   - adc_data_in is captured on the edge-detect cycle.
//   - wr_en asserts 3 clks after the strobe rises; no write while adc_rdy=0.
//  Writer: on each write, wr_addr increments. On the write at index NUM_SAMPLES-1:
//   - other bank free (post-clear value, see Simultaneous): full[wr_bank]<=1, wr_bank toggles, wr_addr<=0.
//   - other bank full: overrun pulse, frame dropped, full[] unchanged, wr_bank unchanged, wr_addr<=0.
//  adc_rdy falling: wr_addr<=0 next clk, wr_bank kept, partial frame discarded.
//  Reader FSM:
//   - R_IDLE: if full[b] is set, rd_bank<=b, eng_start pulse, rd_addr<=0, go to R_STREAM.
//   - R_STREAM: rd_en=1 every clk, rd_addr 0..NUM_SAMPLES-1. After issuing the last index,
//     go to R_WAIT_DONE. sample_valid/sample_last lag rd_en by 1 clk (RAM latency).
//   - R_WAIT_DONE: on eng_done, clear full[rd_bank], frame_done pulse, go to R_IDLE.
//     eng_done in any other state is ignored.
//   - Frame = exactly NUM_SAMPLES consecutive sample_valid cycles, no gaps.
//  Simultaneous: a reader clear and a writer set on the same clk, different banks, both apply.
//   The writer's full check uses the post-clear value, so no overrun.
//   At most one bank is full at any time, apart from that single clk.
//  Index wrap: NS_BITS counters wrap naturally at NUM_SAMPLES (power of 2 required).
//  sys_rst mid-frame: immediate return to reset state; RAM contents are ignored.
// CONFIGURATION
//  GOERTZEL_SCHED_OVCNT_EN defined: overrun_cnt increments on every overrun pulse,
//   saturates at 255, cleared only by sys_rst.
//  Undefined: overrun_cnt tied to 8'd0, no counter logic; the overrun pulse is still produced.
// TESTING
//  1. Reset: sys_rst high for 2 clks mid-fill -> all outputs 0, wr_bank=0, next frame writes from index 0.
//  2. 512 strobes (42 ns wide, 2 us period), ramp data n&0xFF; eng_done 10 clks after sample_last ->
//     one eng_start with rd_bank=0; 512 contiguous sample_valid with data 0..255,0..255;
//     sample_last on the 512th; wr_bank=1; frame_done 1 clk after eng_done.
//  3. eng_done held low, 1024 strobes -> second frame dropped: overrun pulses once at write 1024,
//     wr_bank stays 1, full=01; overrun_cnt=1 with macro defined, 0 without.
//  4. adc_rdy low after 100 strobes, then high, then 512 strobes -> 100 samples discarded;
//     the frame's first sample is the first post-resume sample; one eng_start.
//  5. eng_done on the same clk as the 512th write of bank 1 (bank 0 streamed) -> no overrun,
//     full=10, wr_bank=0, new eng_start for bank 1 within 2 clks.
//  6. Strobe widths of 1, 5 and 40 clks -> exactly one wr_en per strobe, wr_addr +1 each.

Source files
------------

// File: rtl/goertzel_frame_sched.sv
// goertzel_frame_sched
//   Ping-pong frame scheduler between the ADC sample stream and the Goertzel
//   magnitude engine. ADC samples are written into one bank of a two-bank
//   DP-RAM frame buffer (RAM address = {bank, index}). A completed bank is
//   streamed to the engine one sample per clock, and is released when the
//   engine reports its magnitude.
//
//   Optional feature macro: GOERTZEL_SCHED_OVCNT_EN
//     defined   -> overrun_cnt counts overrun pulses, saturating at 255
//     undefined -> overrun_cnt is tied to zero (overrun pulse still produced)
//
// Ports
//   sys_clk, sys_rst     clock, synchronous active-high reset
//   adc_rdy              ADC enabled; low idles the writer and discards a partial frame
//   adc_data_ready       asynchronous sample strobe (>= 1 clk wide)
//   adc_data_in          sample, stable while the strobe is high
//   wr_en/bank/addr/data DP-RAM write port
//   rd_en/bank/addr      DP-RAM read port
//   eng_start            1-clk pulse at frame start
//   sample_valid/last    read data valid (rd_en delayed one clk) / final sample
//   eng_done             engine magnitude ready
//   frame_done           1-clk pulse when a bank is released
//   overrun              1-clk pulse when a completed frame is dropped
//   overrun_cnt          dropped-frame count
module goertzel_frame_sched #(
    parameter int B_W         = 8,
    parameter int NUM_SAMPLES = 512,
    parameter int NS_BITS     = 9
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               adc_rdy,
    input  logic               adc_data_ready,
    input  logic [B_W-1:0]     adc_data_in,
    output logic               wr_en,
    output logic               wr_bank,
    output logic [NS_BITS-1:0] wr_addr,
    output logic [B_W-1:0]     wr_data,
    output logic               rd_en,
    output logic               rd_bank,
    output logic [NS_BITS-1:0] rd_addr,
    output logic               eng_start,
    output logic               sample_valid,
    output logic               sample_last,
    input  logic               eng_done,
    output logic               frame_done,
    output logic               overrun,
    output logic [7:0]         overrun_cnt
);

    localparam logic [NS_BITS-1:0] LAST_IDX = NS_BITS'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {
        R_IDLE      = 2'd0,
        R_STREAM    = 2'd1,
        R_WAIT_DONE = 2'd2
    } rd_state_t;

    rd_state_t  rd_state;
    rd_state_t  rd_state_nxt;

    logic       strb_p0;
    logic       strb_p1;
    logic       strb_p2;
    logic       strb_rise;
    logic [1:0] full;
    logic [1:0] clr_mask;
    logic [1:0] full_post;
    logic       start_now;
    logic       start_bank;
    logic       clear_now;
    logic       last_issue;

    // Strobe synchroniser (p0, p1) plus edge-detect history (p2)
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            strb_p0 <= 1'b0;
            strb_p1 <= 1'b0;
            strb_p2 <= 1'b0;
        end else begin
            strb_p0 <= adc_data_ready;
            strb_p1 <= strb_p0;
            strb_p2 <= strb_p1;
        end
    end

    assign strb_rise = strb_p1 & ~strb_p2;

    // Reader state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) rd_state <= R_IDLE;
        else         rd_state <= rd_state_nxt;
    end

    // Reader next-state and one-cycle decisions
    always_comb begin
        rd_state_nxt = rd_state;
        start_now    = 1'b0;
        start_bank   = 1'b0;
        clear_now    = 1'b0;
        last_issue   = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (|full) begin
                    start_now    = 1'b1;
                    start_bank   = ~full[0];
                    rd_state_nxt = R_STREAM;
                end
            end
            R_STREAM: begin
                if (rd_addr == LAST_IDX) begin
                    last_issue   = 1'b1;
                    rd_state_nxt = R_WAIT_DONE;
                end
            end
            R_WAIT_DONE: begin
                if (eng_done) begin
                    clear_now    = 1'b1;
                    rd_state_nxt = R_IDLE;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    assign rd_en = (rd_state == R_STREAM);

    // The writer's bank-free test sees this cycle's release, so a release and a
    // completion landing on the same clock never produce an overrun.
    assign clr_mask  = clear_now ? (2'b01 << rd_bank) : 2'b00;
    assign full_post = full & ~clr_mask;

    // Writer: capture on edge-detect, write the following cycle
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_en   <= 1'b0;
            wr_data <= '0;
            wr_bank <= 1'b0;
            wr_addr <= '0;
            full    <= 2'b00;
            overrun <= 1'b0;
        end else begin
            wr_en   <= strb_rise & adc_rdy;
            overrun <= 1'b0;
            full    <= full_post;
            if (strb_rise & adc_rdy) wr_data <= adc_data_in;
            if (!adc_rdy) begin
                wr_addr <= '0;
            end else if (wr_en) begin
                // wraps to 0 after the last index of the frame
                wr_addr <= wr_addr + 1'b1;
                if (wr_addr == LAST_IDX) begin
                    if (full_post[~wr_bank]) begin
                        overrun <= 1'b1;
                    end else begin
                        full    <= full_post | (2'b01 << wr_bank);
                        wr_bank <= ~wr_bank;
                    end
                end
            end
        end
    end

    // Reader datapath: sample_valid/last lag the read by the RAM latency
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_bank      <= 1'b0;
            rd_addr      <= '0;
            eng_start    <= 1'b0;
            sample_valid <= 1'b0;
            sample_last  <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            eng_start    <= start_now;
            frame_done   <= clear_now;
            sample_valid <= rd_en;
            sample_last  <= last_issue;
            if (start_now) begin
                rd_bank <= start_bank;
                rd_addr <= '0;
            end else if (rd_en) begin
                rd_addr <= rd_addr + 1'b1;
            end
        end
    end

`ifdef GOERTZEL_SCHED_OVCNT_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst)                            overrun_cnt <= 8'd0;
        else if (overrun && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end
`else
    assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_goertzel_frame_sched.sv
// Testbench for goertzel_frame_sched: randomized strobe stimulus checked every
// cycle against a frame-level reference model, plus literal scenario checks.
module tb_goertzel_frame_sched;
    localparam int B_W         = 8;
    localparam int NUM_SAMPLES = 512;
    localparam int NS_BITS     = 9;

    logic               sys_clk = 1'b0;
    logic               sys_rst;
    logic               adc_rdy;
    logic               adc_data_ready;
    logic [B_W-1:0]     adc_data_in;
    logic               wr_en;
    logic               wr_bank;
    logic [NS_BITS-1:0] wr_addr;
    logic [B_W-1:0]     wr_data;
    logic               rd_en;
    logic               rd_bank;
    logic [NS_BITS-1:0] rd_addr;
    logic               eng_start;
    logic               sample_valid;
    logic               sample_last;
    logic               eng_done;
    logic               frame_done;
    logic               overrun;
    logic [7:0]         overrun_cnt;

    goertzel_frame_sched #(.B_W(B_W), .NUM_SAMPLES(NUM_SAMPLES), .NS_BITS(NS_BITS)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .adc_rdy(adc_rdy),
        .adc_data_ready(adc_data_ready), .adc_data_in(adc_data_in),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .eng_start(eng_start), .sample_valid(sample_valid), .sample_last(sample_last),
        .eng_done(eng_done), .frame_done(frame_done), .overrun(overrun),
        .overrun_cnt(overrun_cnt)
    );

    always #21 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- frame buffer RAM seen by the DUT ----------------
    logic [7:0] ram [2][NUM_SAMPLES];
    logic [7:0] ram_q;
    always @(posedge sys_clk) begin
        if (wr_en) ram[wr_bank][wr_addr] <= wr_data;
        if (rd_en) ram_q <= ram[rd_bank][rd_addr];
    end

    // ---------------- engine: eng_done 10 clks after sample_last ----------------
    bit eng_auto      = 1'b0;
    int force_done_at = -1;
    int eng_timer     = 0;
    int done_cyc      = -1;
    initial begin
        eng_done = 1'b0;
        forever begin
            @(posedge sys_clk); #1;
            eng_done = 1'b0;
            if (sys_rst) eng_timer = 0;
            else if (sample_last === 1'b1 && eng_auto) eng_timer = 10;
            else if (eng_timer > 0) begin
                eng_timer--;
                if (eng_timer == 0) eng_done = 1'b1;
            end
            if (cyc == force_done_at) eng_done = 1'b1;
            if (eng_done) done_cyc = cyc;
        end
    end

    // ---------------- reference model ----------------
    int         wq_due[$];
    logic [7:0] wq_data[$];
    logic [7:0] cur_frame[$];
    logic [7:0] frame_mem [2][NUM_SAMPLES];
    bit         m_bank = 0;
    int         m_idx  = 0;
    bit [1:0]   m_full = 0;
    int         r_phase = 0;   // 0 idle, 1 streaming, 2 awaiting engine
    bit         r_bank = 0;
    int         r_pos  = 0;
    bit         pend_sv = 0, pend_sl = 0, pend_fd = 0, pend_ov = 0;
    logic [7:0] pend_data = 0;
    int         m_cnt = 0;
    bit         chk_en = 0;

    int n_start = 0, n_fd = 0, n_ov = 0, n_wr = 0, n_last = 0;
    int start_cyc = -1, fd_cyc = -1, ov_cyc = -1;
    bit start_bank = 0;
    logic [7:0] got[$];

    always @(negedge sys_clk) begin : model
        bit write_now;
        write_now = (wq_due.size() > 0) && (wq_due[0] == cyc);
        if (chk_en) begin
            check("wr_en", wr_en, write_now);
            check("wr_bank", wr_bank, m_bank);
            check("wr_addr", wr_addr, m_idx);
            if (write_now) check("wr_data", wr_data, wq_data[0]);
            check("rd_en", rd_en, r_phase == 1);
            check("rd_bank", rd_bank, r_bank);
            if (r_phase == 1) check("rd_addr", rd_addr, r_pos);
            check("eng_start", eng_start, r_phase == 1 && r_pos == 0);
            check("sample_valid", sample_valid, pend_sv);
            check("sample_last", sample_last, pend_sl);
            if (pend_sv) check("sample_data", ram_q, pend_data);
            check("frame_done", frame_done, pend_fd);
            check("overrun", overrun, pend_ov);
            check("overrun_cnt", overrun_cnt, m_cnt);
        end
        if (eng_start === 1'b1) begin n_start++; start_cyc = cyc; start_bank = rd_bank; end
        if (frame_done === 1'b1) begin n_fd++; fd_cyc = cyc; end
        if (overrun === 1'b1) begin n_ov++; ov_cyc = cyc; end
        if (wr_en === 1'b1) n_wr++;
        if (sample_last === 1'b1) n_last++;
        if (sample_valid === 1'b1) got.push_back(ram_q);

`ifdef GOERTZEL_SCHED_OVCNT_EN
        if (pend_ov && m_cnt != 255) m_cnt++;
`endif
        pend_sv = 0; pend_sl = 0; pend_fd = 0; pend_ov = 0;

        case (r_phase)
            0: if (m_full != 2'b00) begin
                   r_bank  = m_full[0] ? 1'b0 : 1'b1;
                   r_phase = 1;
                   r_pos   = 0;
               end
            1: begin
                   pend_sv   = 1;
                   pend_data = frame_mem[r_bank][r_pos];
                   pend_sl   = (r_pos == NUM_SAMPLES - 1);
                   r_pos++;
                   if (r_pos == NUM_SAMPLES) r_phase = 2;
               end
            default: if (eng_done) begin
                   m_full[r_bank] = 1'b0;
                   pend_fd = 1;
                   r_phase = 0;
               end
        endcase

        if (!adc_rdy) begin
            m_idx = 0;
            cur_frame.delete();
        end else if (write_now) begin
            cur_frame.push_back(wq_data[0]);
            if (m_idx == NUM_SAMPLES - 1) begin
                if (m_full[!m_bank]) pend_ov = 1;
                else begin
                    for (int i = 0; i < NUM_SAMPLES; i++) frame_mem[m_bank][i] = cur_frame[i];
                    m_full[m_bank] = 1'b1;
                    m_bank = !m_bank;
                end
                cur_frame.delete();
                m_idx = 0;
            end else m_idx++;
        end
        if (write_now) begin
            void'(wq_due.pop_front());
            void'(wq_data.pop_front());
        end

        if (sys_rst) begin
            m_bank = 0; m_idx = 0; m_full = 0; r_phase = 0; r_bank = 0; r_pos = 0;
            pend_sv = 0; pend_sl = 0; pend_fd = 0; pend_ov = 0; m_cnt = 0;
            cur_frame.delete(); wq_due.delete(); wq_data.delete();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic strobe(input logic [7:0] d, input int w, input bit arm, output int due);
        @(posedge sys_clk); #1;
        adc_data_in    = d;
        adc_data_ready = 1'b1;
        due = cyc + 3;
        if (adc_rdy) begin wq_due.push_back(due); wq_data.push_back(d); end
        if (arm) force_done_at = due;
        repeat (w) @(posedge sys_clk);
        #1 adc_data_ready = 1'b0;
        repeat ($urandom_range(2, 4)) @(posedge sys_clk);
    endtask

    task automatic rnd_strobes(input int n);
        int due;
        for (int i = 0; i < n; i++) strobe(8'($urandom), $urandom_range(1, 3), 1'b0, due);
    endtask

    task automatic settle();
        repeat (5) @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge sys_clk); #1 sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
    endtask

    task automatic wait_frame_done(input string name, input int budget);
        int base = n_fd;
        int k = 0;
        while (n_fd == base && k < budget) begin @(posedge sys_clk); k++; end
        #1;
        check(name, n_fd != base, 1'b1);
    endtask

    initial begin
        #(42 * 95000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int due, due_last, s0, f0, o0, l0, w0;
        logic [7:0] d0, dl;
        logic [NS_BITS-1:0] a0;
        sys_rst = 1'b1; adc_rdy = 1'b0; adc_data_ready = 1'b0; adc_data_in = '0;
        repeat (3) @(posedge sys_clk);
        #1 chk_en = 1'b1;
        sys_rst = 1'b0;
        check("reset_ctrl", {wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr, eng_start},
              32'd0);
        check("reset_misc", {wr_data, sample_valid, sample_last, frame_done, overrun, overrun_cnt},
              32'd0);

        // 1: reset in the middle of a fill
        adc_rdy = 1'b1;
        rnd_strobes(200);
        settle();
        check("t1_addr_before_reset", wr_addr, 200);
        do_reset();
        check("t1_addr_after_reset", {wr_bank, wr_addr}, 0);
        check("t1_outputs_after_reset", {wr_en, rd_en, eng_start, sample_valid, frame_done, overrun}, 0);

        // 2: one ramp frame, engine answers 10 clks after sample_last
        eng_auto = 1'b1;
        s0 = n_start; l0 = n_last; got.delete();
        for (int n = 0; n < NUM_SAMPLES; n++) strobe(8'(n), $urandom_range(1, 3), 1'b0, due);
        wait_frame_done("t2_frame_done", 2000);
        check("t2_eng_starts", n_start - s0, 1);
        check("t2_start_bank", start_bank, 0);
        check("t2_sample_count", got.size(), NUM_SAMPLES);
        check("t2_last_count", n_last - l0, 1);
        check("t2_sample0", got[0], 8'd0);
        check("t2_sample255", got[255], 8'd255);
        check("t2_sample256", got[256], 8'd0);
        check("t2_sample511", got[511], 8'd255);
        check("t2_wr_bank", wr_bank, 1);
        check("t2_done_to_frame_done", fd_cyc - done_cyc, 1);

        // 3: engine stalled, 1024 strobes -> second frame dropped
        do_reset();
        eng_auto = 1'b0;
        o0 = n_ov;
        for (int n = 0; n < 2 * NUM_SAMPLES; n++) strobe(8'($urandom), $urandom_range(1, 3), 1'b0, due);
        settle();
        check("t3_overrun_pulses", n_ov - o0, 1);
        check("t3_overrun_timing", ov_cyc, due + 1);
        check("t3_wr_bank", wr_bank, 1);
`ifdef GOERTZEL_SCHED_OVCNT_EN
        check("t3_overrun_cnt", overrun_cnt, 1);
`else
        check("t3_overrun_cnt", overrun_cnt, 0);
`endif
        force_done_at = cyc + 2;
        wait_frame_done("t3_release", 20);

        // 4: adc_rdy drop discards a partial frame
        eng_auto = 1'b1;
        rnd_strobes(100);
        settle();
        adc_rdy = 1'b0;
        repeat (5) @(posedge sys_clk);
        #1 adc_rdy = 1'b1;
        repeat (2) @(posedge sys_clk);
        s0 = n_start; got.delete();
        d0 = 8'($urandom);
        dl = 8'h00;
        strobe(d0, 2, 1'b0, due);
        for (int n = 1; n < NUM_SAMPLES; n++) begin
            dl = 8'($urandom);
            strobe(dl, $urandom_range(1, 3), 1'b0, due);
        end
        wait_frame_done("t4_frame_done", 2000);
        check("t4_eng_starts", n_start - s0, 1);
        check("t4_start_bank", start_bank, 1);
        check("t4_first_sample", got[0], d0);
        check("t4_last_sample", got[NUM_SAMPLES-1], dl);

        // 5: engine done coincides with the final write of the other bank
        eng_auto = 1'b0;
        o0 = n_ov; f0 = n_fd;
        rnd_strobes(NUM_SAMPLES);
        rnd_strobes(NUM_SAMPLES - 1);
        strobe(8'($urandom), 1, 1'b1, due_last);
        w0 = 0;
        while (start_cyc <= due_last && w0 < 10) begin @(posedge sys_clk); w0++; end
        #1;
        check("t5_start_latency", (start_cyc > due_last) && (start_cyc - due_last <= 2), 1'b1);
        check("t5_start_bank", start_bank, 1);
        check("t5_no_overrun", n_ov - o0, 0);
        check("t5_bank0_released", n_fd - f0, 1);
        check("t5_wr_bank", wr_bank, 0);
        l0 = n_last; w0 = 0;
        while (n_last == l0 && w0 < 1000) begin @(posedge sys_clk); w0++; end
        #1;
        check("t5_stream_end", n_last - l0, 1);
        force_done_at = cyc + 2;
        wait_frame_done("t5_release", 20);

        // 6: strobe widths 1, 5, 40 -> one write each
        settle();
        a0 = wr_addr; w0 = n_wr;
        strobe(8'h11, 1, 1'b0, due);
        strobe(8'h55, 5, 1'b0, due);
        strobe(8'hA0, 40, 1'b0, due);
        settle();
        check("t6_write_count", n_wr - w0, 3);
        check("t6_wr_addr", wr_addr, NS_BITS'(a0 + 3));

        settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
